mem_access_unit: RTL and testbench

Memory-stage load/store unit of the pipelined RV32I core. Converts the M-stage load/store control into a valid/ready data-bus transaction and handles byte-lane alignment and load sign extension. It also drives the stall request that freezes F/D/E/M while a bus access is outstanding. It is the requester side of the stall path: the hazard block only consumes stall/flush conditions, and this block originates the multi-cycle memory stall.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/load_align.sv | 28 ++
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// FSM state type, timeout default and the byte-lane offset helper.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    // Lane offset within the word: halfwords only honour addr[1], words none.
    function automatic logic [1:0] lane_offset(input logic [2:0] funct3, input logic [1:0] addr);
        logic [1:0] off;
        case (funct3)
            F3_B, F3_BU: off = addr;
            F3_H, F3_HU: off = {addr[1], 1'b0};
            default:     off = 2'b00;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: selects the byte/half/word lane from the
// bus word and sign- or zero-extends it according to funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata
);

    logic [1:0]  off_s;
    logic [31:0] shifted_s;

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    always_comb begin
        off_s     = lane_offset(i_funct3, i_addr);
        shifted_s = i_word >> {off_s, 3'b000};
        case (i_funct3)
            F3_B:    o_rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_BU:   o_rdata = {24'h000000, shifted_s[7:0]};
            F3_H:    o_rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_HU:   o_rdata = {16'h0000, shifted_s[15:0]};
            default: o_rdata = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns M-stage load/store control into a
// valid/ready bus transaction, raises the pipeline stall while it is
// outstanding and aligns load data. Define MEM_MISALIGN_TRAP_EN to flag
// misaligned halfword/word accesses instead of issuing them.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ctrl_m_mem_read,
    input  logic        i_ctrl_m_mem_write,
    input  logic [2:0]  i_ctrl_m_funct3,
    input  logic [31:0] i_data_m_addr,
    input  logic [31:0] i_data_m_wdata,
    output logic [31:0] o_data_m_rdata,
    output logic        o_data_m_stall,
    output logic        o_data_m_bus_err,
    output logic        o_data_m_misaligned,
    output logic        o_bus_req_valid,
    input  logic        i_bus_req_ready,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_rsp_valid,
    input  logic [31:0] i_bus_rdata
);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;
    logic        mem_op_s, mis_s, op_s, timeout_s;
    logic [1:0]  lane_s;
    logic [31:0] aligned_s;

    // Gating with reset forces every output low while reset is held.
    assign mem_op_s = i_rst_n & (i_ctrl_m_mem_read | i_ctrl_m_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_s = mem_op_s &
                   ((((i_ctrl_m_funct3 == F3_H) || (i_ctrl_m_funct3 == F3_HU)) && i_data_m_addr[0]) ||
                    ((i_ctrl_m_funct3 == F3_W) && (i_data_m_addr[1:0] != 2'b00)));
`else
    assign mis_s = 1'b0;
`endif

    assign op_s      = mem_op_s & ~mis_s;
    assign timeout_s = (cnt_q == (TIMEOUT - 8'd1));
    assign lane_s    = lane_offset(i_ctrl_m_funct3, i_data_m_addr[1:0]);

    load_align u_load_align (
        .i_word   (word_q),
        .i_addr   (i_data_m_addr[1:0]),
        .i_funct3 (i_ctrl_m_funct3),
        .o_rdata  (aligned_s)
    );

    // State register with timeout counter, captured read word and error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            word_q  <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; normal completion wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = 8'd0;
                word_d = 32'h0000_0000;
                if (op_s && i_bus_req_ready) begin
                    state_d = i_ctrl_m_mem_read ? WAIT : DONE;
                end else if (op_s) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (i_bus_req_ready) begin
                    state_d = i_ctrl_m_mem_read ? WAIT : DONE;
                end else if (timeout_s) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (i_bus_rsp_valid) begin
                    word_d  = i_bus_rdata;
                    state_d = DONE;
                end else if (timeout_s) begin
                    word_d  = 32'h0000_0000;
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: handshake, stall and the load result presented in DONE.
    always_comb begin
        o_bus_req_valid = 1'b0;
        o_data_m_stall  = 1'b0;
        o_data_m_rdata  = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                o_bus_req_valid = op_s;
                o_data_m_stall  = op_s;
            end
            REQ: begin
                o_bus_req_valid = 1'b1;
                o_data_m_stall  = 1'b1;
            end
            WAIT: o_data_m_stall = 1'b1;
            DONE: o_data_m_rdata = aligned_s;
            default: o_data_m_stall = 1'b0;
        endcase
    end

    // Request fields follow the frozen M-stage inputs directly.
    always_comb begin
        o_bus_we    = 1'b0;
        o_bus_addr  = 32'h0000_0000;
        o_bus_wdata = 32'h0000_0000;
        o_bus_be    = 4'b0000;
        if (op_s) begin
            o_bus_we   = i_ctrl_m_mem_write;
            o_bus_addr = {i_data_m_addr[31:2], 2'b00};
            if (i_ctrl_m_mem_write) begin
                case (i_ctrl_m_funct3)
                    F3_B: begin
                        o_bus_be    = 4'b0001 << lane_s;
                        o_bus_wdata = {4{i_data_m_wdata[7:0]}};
                    end
                    F3_H: begin
                        o_bus_be    = 4'b0011 << lane_s;
                        o_bus_wdata = {2{i_data_m_wdata[15:0]}};
                    end
                    default: begin
                        o_bus_be    = 4'b1111;
                        o_bus_wdata = i_data_m_wdata;
                    end
                endcase
            end else begin
                o_bus_be = 4'b1111;
            end
        end else begin
            o_bus_we = 1'b0;
        end
    end

    assign o_data_m_bus_err    = err_q;
    assign o_data_m_misaligned = mis_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (TIMEOUT=8): scenario tasks drive a
// small bus responder and compare results against a queue of expected values.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_i, wr_i;
    logic [2:0]  f3_i;
    logic [31:0] addr_i, wd_i;
    logic [31:0] rdata_o;
    logic        stall_o, err_o, mis_o, valid_o, ready_i, we_o;
    logic [31:0] baddr_o, bwd_o;
    logic [3:0]  be_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.TIMEOUT(8'd8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ctrl_m_mem_read(rd_i), .i_ctrl_m_mem_write(wr_i),
        .i_ctrl_m_funct3(f3_i), .i_data_m_addr(addr_i), .i_data_m_wdata(wd_i),
        .o_data_m_rdata(rdata_o), .o_data_m_stall(stall_o),
        .o_data_m_bus_err(err_o), .o_data_m_misaligned(mis_o),
        .o_bus_req_valid(valid_o), .i_bus_req_ready(ready_i),
        .o_bus_we(we_o), .o_bus_addr(baddr_o), .o_bus_wdata(bwd_o), .o_bus_be(be_o),
        .i_bus_rsp_valid(rsp_valid_i), .i_bus_rdata(rsp_data_i)
    );

    always #5 clk = ~clk;

    // Observed results of one access, filled by the driver.
    logic [31:0] ob_rdata, ob_addr, ob_wd;
    logic        ob_err, ob_done, ob_stable, ob_we, ob_mis;
    logic [3:0]  ob_be;
    int          ob_stalls;

    task automatic idle();
        @(negedge clk);
        rd_i = 1'b0; wr_i = 1'b0; f3_i = 3'b000; addr_i = 32'h0; wd_i = 32'h0;
        ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = 32'h0;
    endtask

    // Drives one op in M, acts as the bus slave, stops at the first unstalled cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] word, input int ready_lat, input int rsp_lat);
        int req_n;
        int since;
        req_n = 0; since = -1; ob_stalls = 0; ob_done = 1'b0; ob_stable = 1'b1;
        ob_rdata = 32'h0; ob_err = 1'b0;
        for (int cyc = 0; cyc < 300 && !ob_done; cyc++) begin
            @(negedge clk);
            if (since >= 0) since++;
            rd_i = rd; wr_i = wr; f3_i = f3; addr_i = addr; wd_i = wd;
            ready_i     = (req_n >= ready_lat);
            rsp_valid_i = rd && (since >= 1) && (since == rsp_lat);
            rsp_data_i  = rsp_valid_i ? word : 32'h0;
            #1;
            if (cyc == 0) begin
                ob_addr = baddr_o; ob_wd = bwd_o; ob_be = be_o; ob_we = we_o; ob_mis = mis_o;
            end else if (valid_o && {baddr_o, bwd_o, be_o, we_o} != {ob_addr, ob_wd, ob_be, ob_we}) begin
                ob_stable = 1'b0;
            end
            if (!stall_o) begin
                ob_rdata = rdata_o; ob_err = err_o; ob_done = 1'b1;
            end else begin
                ob_stalls++;
                if (valid_o) begin
                    if (ready_i) since = 0;
                    else req_n++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rd_i = 1'b0; wr_i = 1'b0; f3_i = 3'b000; addr_i = 32'h0; wd_i = 32'h0;
        ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({rdata_o, stall_o, err_o, mis_o, valid_o, we_o, baddr_o, bwd_o, be_o} !== 101'd0) begin
            errors++; $display("FAIL reset_outputs got stall=%b valid=%b addr=%h be=%b exp all zero", stall_o, valid_o, baddr_o, be_o);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_load_word();
        logic [31:0] e;
        exp_q.push_back(32'hDEAD_BEEF);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1);
        e = exp_q.pop_front();
        checks++; if (ob_rdata !== e) begin errors++; $display("FAIL lw_rdata got %h exp %h", ob_rdata, e); end
        checks++; if (ob_stalls !== 2) begin errors++; $display("FAIL lw_stalls got %0d exp 2", ob_stalls); end
        checks++; if ({ob_be, ob_we, ob_addr} !== {4'b1111, 1'b0, 32'h0000_0100}) begin
            errors++; $display("FAIL lw_fields got be=%b we=%b addr=%h exp be=1111 we=0 addr=00000100", ob_be, ob_we, ob_addr);
        end
        checks++; if (ob_err !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", ob_err); end
        idle();
    endtask

    task automatic test_load_extend();
        logic [2:0]  tf3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
        logic [31:0] tadr [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100};
        logic [31:0] tword[6] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_0000, 32'h8001_0000, 32'h1234_567F, 32'h1234_5678};
        logic [31:0] texp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_007F, 32'h0000_5678};
        logic [31:0] e;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(texp[i]);
            access(1'b1, 1'b0, tf3[i], tadr[i], 32'h0, tword[i], 0, 1);
            e = exp_q.pop_front();
            checks++; if (ob_rdata !== e) begin errors++; $display("FAIL load_ext[%0d] got %h exp %h", i, ob_rdata, e); end
        end
        idle();
    endtask

    task automatic test_store();
        access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0, 3, -1);
        checks++; if ({ob_be, ob_wd, ob_we, ob_addr} !== {4'b1100, 32'h1234_1234, 1'b1, 32'h0000_0100}) begin
            errors++; $display("FAIL sh_fields got be=%b wd=%h we=%b addr=%h exp be=1100 wd=12341234 we=1 addr=00000100", ob_be, ob_wd, ob_we, ob_addr);
        end
        checks++; if (ob_stalls !== 4) begin errors++; $display("FAIL sh_stalls got %0d exp 4", ob_stalls); end
        checks++; if (ob_stable !== 1'b1) begin errors++; $display("FAIL sh_stable got %b exp 1", ob_stable); end
        idle();
        access(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0, 0, -1);
        checks++; if ({ob_be, ob_wd, ob_stalls} !== {4'b0010, 32'hABAB_ABAB, 32'd1}) begin
            errors++; $display("FAIL sb_fields got be=%b wd=%h stalls=%0d exp be=0010 wd=abababab stalls=1", ob_be, ob_wd, ob_stalls);
        end
        access(1'b0, 1'b1, 3'b010, 32'h0000_010C, 32'h1122_3344, 32'h0, 0, -1);
        checks++; if ({ob_be, ob_wd, ob_addr} !== {4'b1111, 32'h1122_3344, 32'h0000_010C}) begin
            errors++; $display("FAIL sw_fields got be=%b wd=%h addr=%h exp be=1111 wd=11223344 addr=0000010c", ob_be, ob_wd, ob_addr);
        end
        idle();
    endtask

    task automatic test_req_wait();
        logic [31:0] e;
        exp_q.push_back(32'h5555_AAAA);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h5555_AAAA, 2, 3);
        e = exp_q.pop_front();
        checks++; if (ob_rdata !== e) begin errors++; $display("FAIL slow_lw_rdata got %h exp %h", ob_rdata, e); end
        checks++; if (ob_stalls !== 6) begin errors++; $display("FAIL slow_lw_stalls got %0d exp 6", ob_stalls); end
        idle();
    endtask

    task automatic test_no_mem();
        access(1'b0, 1'b0, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'h0, 0, -1);
        checks++; if ({ob_stalls, ob_be, ob_addr, ob_we} !== {32'd0, 4'b0000, 32'h0, 1'b0}) begin
            errors++; $display("FAIL no_mem got stalls=%0d be=%b addr=%h exp 0/0000/00000000", ob_stalls, ob_be, ob_addr);
        end
        idle();
    endtask

    task automatic test_timeout();
        logic [31:0] e;
        access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0, -1);
        checks++; if (ob_done !== 1'b1) begin errors++; $display("FAIL to_done got %b exp 1", ob_done); end
        checks++; if ({ob_err, ob_rdata, ob_stalls} !== {1'b1, 32'h0, 32'd9}) begin
            errors++; $display("FAIL to_result got err=%b rdata=%h stalls=%0d exp 1/00000000/9", ob_err, ob_rdata, ob_stalls);
        end
        idle();
        rsp_valid_i = 1'b1; rsp_data_i = 32'hFFFF_FFFF;
        #1;
        checks++; if ({err_o, stall_o, valid_o, rdata_o} !== 35'd0) begin
            errors++; $display("FAIL to_late_rsp got err=%b stall=%b rdata=%h exp 0/0/00000000", err_o, stall_o, rdata_o);
        end
        exp_q.push_back(32'h0BAD_F00D);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 0, 1);
        e = exp_q.pop_front();
        checks++; if ({ob_rdata, ob_err} !== {e, 1'b0}) begin errors++; $display("FAIL to_recover got %h err=%b exp %h err=0", ob_rdata, ob_err, e); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        exp_q.push_back(32'h0102_0304);
        exp_q.push_back(32'h0000_00C3);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h0102_0304, 0, 1);
        e = exp_q.pop_front();
        checks++; if (ob_rdata !== e) begin errors++; $display("FAIL b2b_first got %h exp %h", ob_rdata, e); end
        access(1'b1, 1'b0, 3'b100, 32'h0000_0402, 32'h0, 32'h11C3_2233, 0, 1);
        e = exp_q.pop_front();
        checks++; if ({ob_rdata, ob_stalls} !== {e, 32'd2}) begin errors++; $display("FAIL b2b_second got %h stalls=%0d exp %h stalls=2", ob_rdata, ob_stalls, e); end
        idle();
    endtask

    task automatic test_misaligned();
`ifdef MEM_MISALIGN_TRAP_EN
        access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0, 1);
        checks++; if ({ob_mis, ob_stalls, ob_be, ob_rdata} !== {1'b1, 32'd0, 4'b0000, 32'h0}) begin
            errors++; $display("FAIL mis_trap got mis=%b stalls=%0d be=%b rdata=%h exp 1/0/0000/0", ob_mis, ob_stalls, ob_be, ob_rdata);
        end
`else
        logic [31:0] e;
        exp_q.push_back(32'hCAFE_0001);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'hCAFE_0001, 0, 1);
        e = exp_q.pop_front();
        checks++; if ({ob_mis, ob_addr, ob_stalls, ob_rdata} !== {1'b0, 32'h0000_0100, 32'd2, e}) begin
            errors++; $display("FAIL mis_read got mis=%b addr=%h stalls=%0d rdata=%h exp 0/00000100/2/%h", ob_mis, ob_addr, ob_stalls, ob_rdata, e);
        end
`endif
        idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        @(negedge clk);
        rd_i = 1'b1; f3_i = 3'b010; addr_i = 32'h0000_0100; ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        #1;
        checks++; if ({stall_o, valid_o} !== 2'b10) begin errors++; $display("FAIL rst_mid_wait got stall=%b valid=%b exp 1/0", stall_o, valid_o); end
        rst_n = 1'b0;
        #1;
        checks++; if ({rdata_o, stall_o, err_o, mis_o, valid_o, we_o, baddr_o, bwd_o, be_o} !== 101'd0) begin
            errors++; $display("FAIL rst_mid_outputs got stall=%b valid=%b addr=%h be=%b exp all zero", stall_o, valid_o, baddr_o, be_o);
        end
        idle();
        rst_n = 1'b1;
        exp_q.push_back(32'h7654_3210);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h7654_3210, 0, 1);
        e = exp_q.pop_front();
        checks++; if ({ob_rdata, ob_stalls} !== {e, 32'd2}) begin errors++; $display("FAIL rst_recover got %h stalls=%0d exp %h stalls=2", ob_rdata, ob_stalls, e); end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_req_wait();
        test_no_mem();
        test_timeout();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
